// File: rtl/ifu_fetch_queue.sv
// Instruction fetch: PC owner, single-outstanding memory requests, {pc,inst} FIFO to decode.
// Optional IFU_PERF_CNT_EN adds fetched/dropped/stall event counters.
module ifu_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              MEM_DW   = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_req_valid,
  input  logic              io_req_ready,
  output logic [XLEN-1:0]   io_req_addr,
  input  logic              io_resp_valid,
  input  logic [MEM_DW-1:0] io_resp_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [XLEN-1:0]   io_out_pc,
  output logic [31:0]       io_out_inst,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]       io_perf_fetched,
  output logic [63:0]       io_perf_dropped,
  output logic [63:0]       io_perf_stall,
`endif
  input  logic              io_redir_valid,
  input  logic [XLEN-1:0]   io_redir_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [XLEN-1:0] RST_PC = {RESET_PC[XLEN-1:2], 2'b00};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];

  logic        push;
  logic        pop;
  logic        resp_drop;
  logic [31:0] resp_inst;

  logic unused_redir_lsb;
  assign unused_redir_lsb = ^io_redir_pc[1:0];

  if (MEM_DW == 64) begin : g_dw64
    assign resp_inst = req_pc_q[2] ? io_resp_data[63:32]
                                   : io_resp_data[31:0];
  end else begin : g_dw32
    assign resp_inst = io_resp_data[31:0];
  end

  assign io_req_valid = (state_q == REQ);
  assign io_req_addr  = req_pc_q;
  assign io_out_valid = (count_q != '0);
  assign io_out_pc    = pc_mem_q[rd_ptr_q];
  assign io_out_inst  = inst_mem_q[rd_ptr_q];

  assign pop = io_out_valid && io_out_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    resp_drop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!io_redir_valid && (count_q < CW'(DEPTH))) begin
          state_d  = REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (io_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (io_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !io_redir_valid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end else begin
            resp_drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect retargets the PC; an outstanding beat must be discarded later
    if (io_redir_valid) begin
      fetch_pc_d = {io_redir_pc[XLEN-1:2], 2'b00};
      if (state_q == REQ || (state_q == WAIT && !io_resp_valid))
        drop_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]   = req_pc_q;
      inst_mem_d[wr_ptr_q] = resp_inst;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (io_redir_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      req_pc_q   <= RST_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetched_q, fetched_d;
  logic [63:0] dropped_q, dropped_d;
  logic [63:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + {63'd0, push};
    dropped_d = dropped_q + {63'd0, resp_drop};
    stall_d   = stall_q + {63'd0, (state_q == REQ) && !io_req_ready};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
      stall_q   <= stall_d;
    end
  end

  assign io_perf_fetched = fetched_q;
  assign io_perf_dropped = dropped_q;
  assign io_perf_stall   = stall_q;
`else
  logic unused_drop;
  assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: fetch, full FIFO, redirects, drop, PC wrap.
module tb_ifu_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redir_valid = 1'b0;
  logic [63:0] redir_pc = '0;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [63:0] D0 = 64'hAAAA_BBBB_1111_2222;
  localparam logic [63:0] D1 = 64'h0BAD_F00D_1234_5678;
  localparam logic [63:0] D2 = 64'hCAFE_0001_DEAD_0002;
  localparam logic [63:0] D3 = 64'h7777_6666_5555_4444;

  always #5 clock = ~clock;

  ifu_fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .io_req_valid   (req_valid),
    .io_req_ready   (req_ready),
    .io_req_addr    (req_addr),
    .io_resp_valid  (resp_valid),
    .io_resp_data   (resp_data),
    .io_out_valid   (out_valid),
    .io_out_ready   (out_ready),
    .io_out_pc      (out_pc),
    .io_out_inst    (out_inst),
    .io_redir_valid (redir_valid),
    .io_redir_pc    (redir_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 64'(req_valid), 64'd1);
  endtask

  task automatic do_fetch(input string tag, input logic [63:0] addr,
                          input logic [63:0] data);
    wait_req(tag);
    chk({tag, "_addr"}, req_addr, addr);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = data;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    do_fetch("f0", 64'h8000_0000, D0);
    chk("f0_valid", 64'(out_valid), 64'd1);
    chk("f0_pc", out_pc, 64'h8000_0000);
    chk("f0_inst", 64'(out_inst), 64'h1111_2222);
    do_fetch("f1", 64'h8000_0004, D0);
    pop1();
    chk("f1_pc", out_pc, 64'h8000_0004);
    chk("f1_inst", 64'(out_inst), 64'hAAAA_BBBB);
    pop1();
    chk("f1_empty", 64'(out_valid), 64'd0);

    do_fetch("full0", 64'h8000_0008, D1);
    do_fetch("full1", 64'h8000_000C, D1);
    do_fetch("full2", 64'h8000_0010, D1);
    do_fetch("full3", 64'h8000_0014, D1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_noreq", 64'(req_valid), 64'd0);
    end
    chk("full_head", out_pc, 64'h8000_0008);
    chk("full_inst", 64'(out_inst), 64'h1234_5678);
    pop1();
    chk("full_pop_pc", out_pc, 64'h8000_000C);
    do_fetch("refill", 64'h8000_0018, D1);

    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0100;
    tick();
    redir_valid = 1'b0;
    chk("idle_redir_flush", 64'(out_valid), 64'd0);
    do_fetch("idle_redir", 64'h8000_0100, D2);
    chk("idle_redir_pc", out_pc, 64'h8000_0100);
    chk("idle_redir_inst", 64'(out_inst), 64'hDEAD_0002);

    wait_req("wr");
    chk("wr_addr", req_addr, 64'h8000_0104);
    req_ready = 1'b1;
    tick();
    req_ready   = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_1002;
    tick();
    redir_valid = 1'b0;
    chk("wait_redir_flush", 64'(out_valid), 64'd0);
    resp_valid = 1'b1;
    resp_data  = D3;
    tick();
    resp_valid = 1'b0;
    chk("wait_redir_drop", 64'(out_valid), 64'd0);
    do_fetch("wait_tgt", 64'h8000_1000, D3);
    chk("wait_tgt_pc", out_pc, 64'h8000_1000);
    chk("wait_tgt_inst", 64'(out_inst), 64'h5555_4444);
    pop1();

    wait_req("st");
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", req_addr, 64'h8000_1004);
      chk("stall_valid", 64'(req_valid), 64'd1);
      redir_valid = (i == 1);
      redir_pc    = 64'h8000_2000;
      tick();
    end
    redir_valid = 1'b0;
    chk("stall_hold", req_addr, 64'h8000_1004);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = D1;
    tick();
    resp_valid = 1'b0;
    chk("stall_drop", 64'(out_valid), 64'd0);
    do_fetch("stall_tgt", 64'h8000_2000, D2);
    chk("stall_tgt_pc", out_pc, 64'h8000_2000);
    pop1();

    wait_req("co");
    chk("co_addr", req_addr, 64'h8000_2004);
    req_ready = 1'b1;
    tick();
    req_ready   = 1'b0;
    resp_valid  = 1'b1;
    resp_data   = D1;
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_3000;
    tick();
    resp_valid  = 1'b0;
    redir_valid = 1'b0;
    chk("co_nopush", 64'(out_valid), 64'd0);
    do_fetch("co_tgt", 64'h8000_3000, D1);
    chk("co_nodrop", 64'(out_valid), 64'd1);
    chk("co_tgt_pc", out_pc, 64'h8000_3000);
    pop1();

    wait_req("wrap");
    redir_valid = 1'b1;
    redir_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redir_valid = 1'b0;
    chk("req_redir_hold", req_addr, 64'h8000_3004);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = D0;
    tick();
    resp_valid = 1'b0;
    chk("req_redir_drop", 64'(out_valid), 64'd0);
    do_fetch("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, D2);
    do_fetch("wrap_zero", 64'h0, D3);
    chk("wrap_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_top_inst", 64'(out_inst), 64'hCAFE_0001);
    pop1();
    chk("wrap_zero_pc", out_pc, 64'h0);
    chk("wrap_zero_inst", 64'(out_inst), 64'h5555_4444);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
